// File: rtl/cpu_trace_buffer.sv
// Trace capture buffer for the single-cycle CPU observation bus: arm/trigger/stop session
// control, cycle-stamped circular record store, show-ahead valid/ready drain port.
// Optional macro TRACE_BUS_AB_EN adds busA/busB to each record.
module cpu_trace_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Run,
    input  logic [31:0]              Instruction,
    input  logic [31:0]              busA,
    input  logic [31:0]              busB,
    input  logic [31:0]              busW,
    input  logic [31:0]              Result,
    input  logic                     Arm,
    input  logic                     Stop,
    input  logic [31:0]              TrigMask,
    input  logic [31:0]              TrigValue,
    input  logic                     RdReady,
    output logic                     RdValid,
    output logic [CNT_W-1:0]         RdCycle,
    output logic [31:0]              RdInstruction,
    output logic [31:0]              RdBusW,
    output logic [31:0]              RdResult,
    output logic [31:0]              RdBusA,
    output logic [31:0]              RdBusB,
    output logic [$clog2(DEPTH):0]   Count,
    output logic [1:0]               State
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             trig_match;
    logic             full;
    logic             pop;
    logic             wr_en;

    logic [CNT_W-1:0] mem_cyc_q   [DEPTH];
    logic [31:0]      mem_instr_q [DEPTH];
    logic [31:0]      mem_busw_q  [DEPTH];
    logic [31:0]      mem_result_q[DEPTH];
`ifdef TRACE_BUS_AB_EN
    logic [31:0]      mem_busa_q  [DEPTH];
    logic [31:0]      mem_busb_q  [DEPTH];
`else
    logic             unused_bus_ab;
    assign unused_bus_ab = ^{busA, busB};
`endif

    assign trig_match = Run && ((Instruction & TrigMask) == (TrigValue & TrigMask));
    // Full uses the registered count, so a same-edge pop never frees a slot for this write.
    assign full       = (count_q == FullCnt);
    assign pop        = (count_q != '0) && RdReady;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        wr_en   = 1'b0;

        if ((state_q == StArmed || state_q == StCapture) && Run) begin
            cyc_d = cyc_q + CNT_W'(1);
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (Arm && !Stop) begin
                    state_d = StArmed;
                    cyc_d   = '0;
                end
            end
            StArmed: begin
                if (Stop) begin
                    state_d = StDone;
                end else if (trig_match) begin
                    // A buffer left full by an earlier session ends the new one at once.
                    if (full) begin
                        state_d = StDone;
                    end else begin
                        wr_en   = 1'b1;
                        state_d = StCapture;
                    end
                end
            end
            StCapture: begin
                if (Stop) begin
                    state_d = StDone;
                end else if (Run) begin
                    if (full) begin
                        state_d = StDone;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(wr_en) - CW'(pop);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= StIdle;
            cyc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Record storage needs no reset: stale slots are never visible while Count is 0.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_cyc_q[wr_ptr_q]    <= cyc_q;
            mem_instr_q[wr_ptr_q]  <= Instruction;
            mem_busw_q[wr_ptr_q]   <= busW;
            mem_result_q[wr_ptr_q] <= Result;
`ifdef TRACE_BUS_AB_EN
            mem_busa_q[wr_ptr_q]   <= busA;
            mem_busb_q[wr_ptr_q]   <= busB;
`endif
        end
    end

    always_comb begin
        RdValid       = 1'b0;
        RdCycle       = '0;
        RdInstruction = '0;
        RdBusW        = '0;
        RdResult      = '0;
        RdBusA        = '0;
        RdBusB        = '0;
        if (count_q != '0) begin
            RdValid       = 1'b1;
            RdCycle       = mem_cyc_q[rd_ptr_q];
            RdInstruction = mem_instr_q[rd_ptr_q];
            RdBusW        = mem_busw_q[rd_ptr_q];
            RdResult      = mem_result_q[rd_ptr_q];
`ifdef TRACE_BUS_AB_EN
            RdBusA        = mem_busa_q[rd_ptr_q];
            RdBusB        = mem_busb_q[rd_ptr_q];
`endif
        end
    end

    assign Count = count_q;
    assign State = state_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: queue-based session model compared every negedge,
// directed literal checks for the key scenarios, then a long randomized run.
module tb_cpu_trace_buffer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = 16;

    logic               Clk, Reset, Run, Arm, Stop, RdReady;
    logic [31:0]        Instruction, busA, busB, busW, Result, TrigMask, TrigValue;
    logic               RdValid;
    logic [CNT_W-1:0]   RdCycle;
    logic [31:0]        RdInstruction, RdBusW, RdResult, RdBusA, RdBusB;
    logic [$clog2(DEPTH):0] Count;
    logic [1:0]         State;

    cpu_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Instruction(Instruction),
        .busA(busA), .busB(busB), .busW(busW), .Result(Result),
        .Arm(Arm), .Stop(Stop), .TrigMask(TrigMask), .TrigValue(TrigValue),
        .RdReady(RdReady), .RdValid(RdValid), .RdCycle(RdCycle),
        .RdInstruction(RdInstruction), .RdBusW(RdBusW), .RdResult(RdResult),
        .RdBusA(RdBusA), .RdBusB(RdBusB), .Count(Count), .State(State)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        int          cyc;
        logic [31:0] ins, bw, res, ba, bb;
    } rec_t;

    rec_t q[$];
    int   m_state;
    int   m_cyc;
    int   n_vec = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_state = 0;
        m_cyc   = 0;
    endfunction

    // Apply one clock edge of session rules to the model, using the inputs the DUT samples.
    function automatic void model_step();
        bit   match, full, pop, wr, clr;
        int   nst;
        rec_t r;
        match = Run && ((Instruction & TrigMask) == (TrigValue & TrigMask));
        full  = (q.size() == DEPTH);
        pop   = (q.size() != 0) && RdReady;
        wr    = 0;
        clr   = 0;
        nst   = m_state;
        if (m_state == 0 || m_state == 3) begin
            if (Arm && !Stop) begin nst = 1; clr = 1; end
        end else if (Stop) begin
            nst = 3;
        end else if ((m_state == 1 && match) || (m_state == 2 && Run)) begin
            if (full) nst = 3;
            else begin wr = 1; nst = 2; end
        end
        r.cyc = m_cyc; r.ins = Instruction; r.bw = busW; r.res = Result;
        r.ba = busA; r.bb = busB;
        if ((m_state == 1 || m_state == 2) && Run) m_cyc = (m_cyc + 1) % (1 << CNT_W);
        if (clr) m_cyc = 0;
        if (pop) void'(q.pop_front());
        if (wr) q.push_back(r);
        m_state = nst;
    endfunction

    always @(negedge Clk) begin
        if (chk_en && !Reset) begin
            rec_t h;
            bit   v;
            v = (q.size() != 0);
            if (v) h = q[0];
            else begin h.cyc = 0; h.ins = 0; h.bw = 0; h.res = 0; h.ba = 0; h.bb = 0; end
            chk("state", State, m_state);
            chk("count", Count, q.size());
            chk("rd_valid", RdValid, v);
            chk("rd_cycle", RdCycle, h.cyc);
            chk("rd_instr", RdInstruction, h.ins);
            chk("rd_busw", RdBusW, h.bw);
            chk("rd_result", RdResult, h.res);
`ifdef TRACE_BUS_AB_EN
            chk("rd_busa", RdBusA, h.ba);
            chk("rd_busb", RdBusB, h.bb);
`else
            chk("rd_busa", RdBusA, 0);
            chk("rd_busb", RdBusB, 0);
`endif
        end
    end

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
        busW   = $urandom;
        Result = $urandom;
        busA   = $urandom;
        busB   = $urandom;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        model_reset();
        #2;
        Reset = 1'b0;
    endtask

    task automatic pulse_arm();
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
    endtask

    logic [5:0]  ops[4];
    logic [31:0] masks[3];
    logic [31:0] r;
    int          bias;

    initial begin
        ops   = '{6'h00, 6'h23, 6'h2B, 6'h04};
        masks = '{32'h0, 32'hFC00_0000, 32'hFFFF_FFFF};
        Reset = 1'b1; Run = 0; Arm = 0; Stop = 0; RdReady = 0;
        Instruction = 0; busA = 0; busB = 0; busW = 0; Result = 0;
        TrigMask = 0; TrigValue = 0;
        model_reset();
        #3 Reset = 1'b0;
        chk("reset_state", State, 0);
        chk("reset_count", Count, 0);
        chk("reset_valid", RdValid, 0);
        chk("reset_cycle", RdCycle, 0);
        chk_en = 1'b1;
        @(posedge Clk); #1;

        // Trigger on first Run cycle, five records.
        do_reset();
        pulse_arm();
        Run = 1; Instruction = $urandom;
        tick();
        chk("t1_state_after_trig", State, 2);
        for (int i = 0; i < 4; i++) begin Instruction = $urandom; tick(); end
        chk("t1_count", Count, 5);
        chk("t1_cycle", RdCycle, 0);
        chk("t1_valid", RdValid, 1);

        // Opcode trigger on lw.
        do_reset();
        Run = 0; TrigMask = 32'hFC00_0000; TrigValue = 32'h8C00_0000;
        pulse_arm();
        Run = 1;
        Instruction = 32'h0022_1820; tick();
        Instruction = 32'h0043_2020; tick();
        Instruction = 32'h8C22_0004; tick();
        Instruction = 32'hAC22_0008; tick();
        chk("t2_instr", RdInstruction, 32'h8C22_0004);
        chk("t2_state", State, 2);
        chk("t2_count", Count, 2);
        chk("t2_cycle", RdCycle, 2);

        // Fill to DEPTH, overflow ends the session, drain in order.
        do_reset();
        Run = 0; TrigMask = 0;
        pulse_arm();
        Run = 1;
        for (int i = 1; i <= 17; i++) begin
            Instruction = $urandom;
            tick();
            if (i == 16) chk("t3_state16", State, 2);
        end
        chk("t3_count", Count, 16);
        chk("t3_state17", State, 3);
        Run = 0; RdReady = 1;
        for (int i = 0; i < 16; i++) begin
            chk("t3_drain_cycle", RdCycle, i);
            tick();
        end
        chk("t3_empty", RdValid, 0);
        RdReady = 0;

        // Stream-through at constant occupancy, then Stop and drain.
        do_reset();
        pulse_arm();
        Run = 1;
        for (int i = 0; i < 3; i++) begin Instruction = $urandom; tick(); end
        RdReady = 1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_stream_cycle", RdCycle, i);
            Instruction = $urandom;
            tick();
            chk("t4_count", Count, 3);
        end
        Run = 0; Stop = 1; tick(); Stop = 0;
        chk("t4_stop_state", State, 3);
        chk("t4_stop_count", Count, 2);
        tick(); tick();
        chk("t4_drained", Count, 0);
        RdReady = 0;

        // Arm+Stop from DONE, then re-arm keeps old records and clears the counter.
        do_reset();
        pulse_arm();
        Run = 1;
        for (int i = 0; i < 4; i++) begin Instruction = $urandom; tick(); end
        Run = 0; Stop = 1; tick();
        Arm = 1; tick(); Arm = 0; Stop = 0;
        chk("t5_arm_stop", State, 3);
        pulse_arm();
        chk("t5_rearm", State, 1);
        chk("t5_kept", Count, 4);
        Run = 1; Instruction = $urandom; tick(); Run = 0;
        chk("t5_count", Count, 5);
        RdReady = 1;
        for (int i = 0; i < 4; i++) tick();
        RdReady = 0;
        chk("t5_new_stamp", RdCycle, 0);
        chk("t5_left", Count, 1);

        // Asynchronous reset mid-capture.
        do_reset();
        pulse_arm();
        Run = 1;
        for (int i = 0; i < 7; i++) begin Instruction = $urandom; tick(); end
        chk("t6_count", Count, 7);
        Reset = 1'b1;
        #1;
        chk("t6_state", State, 0);
        chk("t6_count0", Count, 0);
        chk("t6_valid", RdValid, 0);
        chk("t6_instr", RdInstruction, 0);
        model_reset();
        #1 Reset = 1'b0;

        // Randomized sessions against the model.
        bias = 4;
        for (int n = 0; n < 4000; n++) begin
            if (n % 150 == 0) bias = $urandom_range(0, 8);
            Arm = ($urandom_range(0, 15) == 0);
            Stop = ($urandom_range(0, 39) == 0);
            Run = ($urandom_range(0, 3) != 0);
            RdReady = ($urandom_range(0, 7) < bias);
            r = $urandom;
            Instruction = {ops[$urandom_range(0, 3)], r[25:0]};
            if (Arm) begin
                TrigMask = masks[$urandom_range(0, 2)];
                r = $urandom;
                TrigValue = {ops[$urandom_range(0, 3)], r[25:0]};
            end
            if ($urandom_range(0, 499) == 0) do_reset();
            tick();
        end
        Arm = 0; Stop = 0; Run = 0; RdReady = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
- Passive trace-capture unit on the single_cycle_cpu observation outputs (Run, Instruction, busW, Result, optionally busA/busB).
- Once armed and triggered, it stores one record per Run-high clock in a circular buffer, stamped with a cycle count.
- Records are drained in order through a valid/ready read port, so benches and debug logic can replay executed instructions without sampling the CPU in real time.

Parameters:
- DEPTH, 16: number of trace records; power of two, at least 2.
- CNT_W, 16: width of the cycle stamp counter.

Ports:
- Clk  in  1  rising-edge clock, the same clock that drives the CPU.
- Reset  in  1  asynchronous, active-high reset.
- Run  in  1  CPU run enable; records are taken only when Run=1.
- Instruction  in  32  current CPU instruction.
- busA  in  32  CPU register bus A; stored only with TRACE_BUS_AB_EN.
- busB  in  32  CPU register bus B; stored only with TRACE_BUS_AB_EN.
- busW  in  32  CPU write-back bus.
- Result  in  32  CPU ALU result.
- Arm  in  1  single-cycle pulse that starts a capture session.
- Stop  in  1  single-cycle pulse that forces the session to end.
- TrigMask  in  32  trigger compare mask.
- TrigValue  in  32  trigger compare value.
- RdReady  in  1  consumer accepts the head record.
- RdValid  out  1  head record is valid.
- RdCycle  out  CNT_W  cycle stamp of the head record.
- RdInstruction  out  32  head record instruction.
- RdBusW  out  32  head record busW.
- RdResult  out  32  head record Result.
- RdBusA  out  32  head record busA.
- RdBusB  out  32  head record busB.
- Count  out  $clog2(DEPTH)+1  number of stored records.
- State  out  2  current state: 0=IDLE, 1=ARMED, 2=CAPTURE, 3=DONE.

Behaviour:
- Reset (asynchronous): State=IDLE; Count=0; read and write pointers 0; cycle counter 0; RdValid=0; all Rd* data outputs 0.
- Signals are sampled on the rising edge of Clk.
- Trigger match is defined as: Run=1 and (Instruction & TrigMask) == (TrigValue & TrigMask).
- State transitions, with Stop taking priority over everything else:
  - IDLE: Arm moves to ARMED and clears the cycle counter. Stop has no effect.
  - ARMED: Stop moves to DONE. A trigger match writes the current record and moves to CAPTURE.
  - CAPTURE: Stop moves to DONE with no write. If Run=1 and the buffer is not full, write the record. If Run=1 and the buffer is full, move to DONE with no write. If Run=0, hold.
  - DONE: Arm moves to ARMED and clears the cycle counter. The buffer is NOT flushed by Arm.
  - Arm received in ARMED or CAPTURE is ignored.
  - Arm and Stop on the same edge: Stop wins.
- Cycle counter:
  - Increments on every edge where State is ARMED or CAPTURE and Run=1.
  - Wraps modulo 2^CNT_W.
  - A record's stamp is the counter value before that edge's increment, so the first Run-high cycle after Arm has stamp 0.
- Buffer:
  - Circular, with write and read pointers of $clog2(DEPTH) bits that wrap at DEPTH.
  - Full is defined as Count==DEPTH; the full test uses the registered Count, before any same-cycle pop.
- Read port:
  - Show-ahead: RdValid = (Count != 0), and the Rd* outputs present the head record combinationally from storage.
  - When Count=0, all Rd* data outputs are 0.
  - A pop occurs when RdValid && RdReady; RdReady while empty is ignored.
  - A pop and a write on the same edge leave Count unchanged; the write still obeys the full rule above.
- Reset asserted mid-capture or mid-read discards all records immediately.
- The block never drives the CPU; it is observation-only.

Optional Feature:
- Macro: TRACE_BUS_AB_EN.
- Defined: busA and busB are stored in each record and returned on RdBusA/RdBusB.
- Undefined: there is no storage for busA/busB, and RdBusA/RdBusB are tied to 0. Ports remain present so the interface is identical in both builds.

Test Plan:
- Reset then Arm with TrigMask=0, Run=1 for 5 cycles, RdReady=0 -> after the trigger edge State=CAPTURE; after 5 edges Count=5; RdCycle=0, RdValid=1.
- TrigMask=0xFC000000, TrigValue=0x8C000000 (lw opcode), Arm; feed add, add, lw, sw -> first record RdInstruction is the lw; State=CAPTURE; Count=2 after sw.
- DEPTH=16, armed, trigger always true, Run=1 for 20 cycles -> Count=16; State=DONE on the 17th Run edge; drain gives RdCycle 0..15 in order, then RdValid=0.
- Capture in progress with Count=3: assert RdReady continuously and Run=1 -> Count stays 3 while records stream out in order; Stop pulse -> State=DONE, then Count drains to 0.
- Arm and Stop on the same edge from DONE -> State stays DONE; Arm alone then -> ARMED with the cycle counter cleared and old records retained.
- Reset asserted mid-capture with Count=7 -> State=IDLE, Count=0, RdValid=0 immediately, without waiting for Clk.
